// File: rtl/ram64_initiator.sv
// ram64_initiator: burst command engine in front of a 64x16 RAM port.
// Streams write beats into RAM and returns registered read beats.
module ram64_initiator #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] mem_out
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] remaining;
  logic              cmd_fire;
  logic              wr_beat;
  logic              rd_beat;
  logic              last;

  assign cmd_fire = cmd_valid && cmd_ready;
  assign wr_beat  = (state == WRITE) && wr_valid;
  // a read issues only when the output register is free or draining
  assign rd_beat  = (state == READ) && (!rd_valid || rd_ready);
  assign last     = (remaining == '0);

  assign cmd_ready = (state == IDLE) && !reset;
  assign wr_ready  = (state == WRITE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  assign mem_en      = wr_beat || rd_beat;
  assign mem_rw      = wr_beat;
  assign mem_address = mem_en ? cur_addr : '0;
  assign mem_in      = wr_beat ? wr_data : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_fire) begin
            cur_addr  <= cmd_addr;
            remaining <= cmd_len;
            state     <= cmd_rw ? WRITE : READ;
          end
        end
        WRITE: begin
          if (wr_beat) begin
            cur_addr  <= cur_addr + ADDR_W'(1);
            remaining <= remaining - ADDR_W'(1);
            if (last) state <= DONE;
          end
        end
        READ: begin
          if (rd_beat) begin
            rd_data   <= mem_out;
            rd_valid  <= 1'b1;
            cur_addr  <= cur_addr + ADDR_W'(1);
            remaining <= remaining - ADDR_W'(1);
            if (last) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (rd_valid && rd_ready) begin
            rd_valid <= 1'b0;
            state    <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram64_initiator.sv
// tb_ram64_initiator: directed and random bursts against a RAM model,
// checked with a word-level memory model and expected beat stream.
module tb_ram64_initiator;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_rw = 1'b0;
  logic [5:0]  cmd_addr = '0;
  logic [5:0]  cmd_len = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [15:0] wr_data = '0;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [15:0] rd_data;
  logic        busy;
  logic        done;
  logic        mem_en;
  logic        mem_rw;
  logic [5:0]  mem_address;
  logic [15:0] mem_in;
  logic [15:0] mem_out;

  logic [15:0] ram [64];
  logic [15:0] exp_mem [64];
  int          tests = 0;
  int          fails = 0;

  ram64_initiator #(.ADDR_W(6), .DATA_W(16)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .done(done),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_address(mem_address),
    .mem_in(mem_in), .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_en && mem_rw) ram[mem_address] <= mem_in;

  assign mem_out = (mem_en && !mem_rw) ? ram[mem_address] : 16'h0;

  task automatic chkb(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic start_cmd(input logic rw, input logic [5:0] a,
                           input logic [5:0] l);
    cmd_valid = 1'b1;
    cmd_rw    = rw;
    cmd_addr  = a;
    cmd_len   = l;
    #1;
    chkb("cmd_ready", cmd_ready, 1'b1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_addr  = 6'($urandom);
    cmd_len   = 6'($urandom);
    chkb("cmd_busy", busy, 1'b1);
  endtask

  task automatic end_burst(input string t);
    #1;
    chkb({t, "_done"}, done, 1'b1);
    chkb({t, "_done_busy"}, busy, 1'b1);
    chkb({t, "_done_cmdrdy"}, cmd_ready, 1'b0);
    chkb({t, "_done_en"}, mem_en, 1'b0);
    chkb({t, "_done_rdv"}, rd_valid, 1'b0);
    @(posedge clk);
    #1;
    chkb({t, "_done_clr"}, done, 1'b0);
    chkb({t, "_idle_rdy"}, cmd_ready, 1'b1);
    chkb({t, "_idle_busy"}, busy, 1'b0);
  endtask

  task automatic write_burst(input logic [5:0] a, input int l,
                             input int pct, input logic [15:0] gapm,
                             input logic [15:0] base);
    int          beat = 0;
    int          c = 0;
    logic [15:0] d;
    logic [5:0]  wa;
    start_cmd(1'b1, a, l[5:0]);
    while (beat <= l && c < 400) begin
      wr_valid = !(c < 16 && gapm[c[3:0]]) && ($urandom_range(99) >= pct);
      d = (base != 16'h0) ? base + 16'(beat) : 16'($urandom);
      wr_data = d;
      wa = a + 6'(beat);
      #1;
      chkb("w_wr_ready", wr_ready, 1'b1);
      chkb("w_mem_en", mem_en, wr_valid);
      chkb("w_rd_valid", rd_valid, 1'b0);
      chkb("w_done", done, 1'b0);
      if (wr_valid) begin
        chkb("w_rw", mem_rw, 1'b1);
        chkw("w_addr", 16'(mem_address), 16'(wa));
        chkw("w_in", mem_in, d);
        exp_mem[wa] = d;
        beat++;
      end else begin
        chkw("w_gap_addr", 16'(mem_address), 16'h0);
        chkw("w_gap_in", mem_in, 16'h0);
      end
      @(posedge clk);
      #1;
      c++;
    end
    wr_valid = 1'b0;
    end_burst("w");
  endtask

  task automatic read_burst(input logic [5:0] a, input int l,
                            input int pct, input logic [15:0] stallm);
    int          issued = 0;
    int          got = 0;
    int          c = 0;
    int          n;
    logic        ev = 1'b0;
    logic [15:0] ed = 16'h0;
    logic        rr;
    logic        iss;
    logic [5:0]  ra;
    n = l + 1;
    start_cmd(1'b0, a, l[5:0]);
    while (got < n && c < 600) begin
      rr = !(c < 16 && stallm[c[3:0]]) && ($urandom_range(99) >= pct);
      rd_ready = rr;
      iss = (issued < n) && (!ev || rr);
      ra = a + 6'(issued);
      #1;
      chkb("r_valid", rd_valid, ev);
      if (ev) chkw("r_data", rd_data, ed);
      chkb("r_mem_en", mem_en, iss);
      chkb("r_wr_ready", wr_ready, 1'b0);
      chkb("r_done", done, 1'b0);
      if (iss) begin
        chkb("r_rw", mem_rw, 1'b0);
        chkw("r_addr", 16'(mem_address), 16'(ra));
      end else begin
        chkw("r_idle_addr", 16'(mem_address), 16'h0);
      end
      if (ev && rr) got++;
      if (iss) begin
        ed = exp_mem[ra];
        ev = 1'b1;
        issued++;
      end else if (ev && rr) begin
        ev = 1'b0;
      end
      @(posedge clk);
      #1;
      c++;
    end
    rd_ready = 1'b0;
    end_burst("r");
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ra;
    int         rl;
    int         rp;

    #1 reset = 1'b1;
    #1;
    chkb("rst_cmd_ready", cmd_ready, 1'b0);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_en", mem_en, 1'b0);
    chkb("rst_rd_valid", rd_valid, 1'b0);
    chkw("rst_rd_data", rd_data, 16'h0);
    chkb("rst_done", done, 1'b0);
    chkw("rst_addr", 16'(mem_address), 16'h0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chkb("idle_cmd_ready", cmd_ready, 1'b1);
    chkb("idle_busy", busy, 1'b0);
    chkb("idle_en", mem_en, 1'b0);
    chkb("idle_wr_ready", wr_ready, 1'b0);

    // fill every word once with a wrapping 64-beat burst, read it back
    write_burst(6'd17, 63, 0, 16'h0, 16'h0);
    read_burst(6'd17, 63, 0, 16'h0);

    write_burst(6'd5, 3, 0, 16'h0, 16'h00A1);
    read_burst(6'd5, 3, 0, 16'h0);

    write_burst(6'd62, 3, 0, 16'h0, 16'h0001);
    chkw("wrap_ram62", ram[62], 16'h0001);
    chkw("wrap_ram63", ram[63], 16'h0002);
    chkw("wrap_ram0", ram[0], 16'h0003);
    chkw("wrap_ram1", ram[1], 16'h0004);
    read_burst(6'd62, 3, 0, 16'h0);

    read_burst(6'd5, 2, 0, 16'b1110);

    write_burst(6'd30, 1, 0, 16'b0110, 16'h0055);
    chkw("stall_ram30", ram[30], 16'h0055);
    chkw("stall_ram31", ram[31], 16'h0056);

    // reset lands in the middle of the third beat of an 8-beat write
    start_cmd(1'b1, 6'd40, 6'd7);
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1'b1;
      wr_data  = 16'hB0 + 16'(i);
      #1;
      chkb("mid_beat_en", mem_en, 1'b1);
      exp_mem[6'(40 + i)] = wr_data;
      @(posedge clk);
      #1;
    end
    wr_valid = 1'b1;
    wr_data  = 16'hB2;
    #1;
    chkb("mid_beat2_en", mem_en, 1'b1);
    reset = 1'b1;
    #1;
    chkb("mid_rst_en", mem_en, 1'b0);
    chkb("mid_rst_cmd_ready", cmd_ready, 1'b0);
    chkb("mid_rst_busy", busy, 1'b0);
    chkb("mid_rst_wr_ready", wr_ready, 1'b0);
    chkw("mid_rst_addr", 16'(mem_address), 16'h0);
    chkw("mid_rst_in", mem_in, 16'h0);
    @(posedge clk);
    #1;
    chkb("mid_rst_hold_en", mem_en, 1'b0);
    chkw("mid_ram42", ram[42], exp_mem[42]);
    reset = 1'b0;
    #1;
    chkb("post_rst_ready", cmd_ready, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chkb("post_rst_en", mem_en, 1'b0);
      chkb("post_rst_wr_ready", wr_ready, 1'b0);
    end
    wr_valid = 1'b0;
    read_burst(6'd40, 0, 0, 16'h0);
    chkw("mid_ram40", ram[40], 16'h00B0);

    for (int k = 0; k < 24; k++) begin
      ra = 6'($urandom);
      rl = int'($urandom_range(20));
      rp = int'($urandom_range(50));
      if ($urandom_range(1) == 1)
        write_burst(ra, rl, rp, 16'h0, 16'h0);
      else
        read_burst(ra, rl, rp, 16'h0);
    end

    for (int i = 0; i < 64; i++)
      chkw("final_ram", ram[i], exp_mem[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ram64_initiator.md
Name: ram64_initiator

Overview:
Burst memory initiator that drives the 64 x 16 RAM port (en, rw, address, in, out) on behalf of a streaming client.
- Accepts one command: direction, start address, length.
- Write bursts move data from a valid/ready stream into RAM; read bursts move RAM words into a registered valid/ready output stream.
- Addresses auto-increment with wrap. The block sits between datapath logic and the RAM64 instance.

Parameters:
ADDR_W, 6, RAM address width (64 words)
DATA_W, 16, word width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
cmd_valid  input  1  command offered
cmd_ready  output  1  block idle, command accepted when cmd_valid&cmd_ready
cmd_rw  input  1  1=write burst, 0=read burst
cmd_addr  input  ADDR_W  start address
cmd_len  input  ADDR_W  beats minus 1 (0 -> 1 beat, 63 -> 64 beats)
wr_valid  input  1  write data available
wr_ready  output  1  write beat accepted when wr_valid&wr_ready
wr_data  input  DATA_W  write word
rd_valid  output  1  rd_data holds a read word
rd_ready  input  1  consumer takes word when rd_valid&rd_ready
rd_data  output  DATA_W  read word (registered)
busy  output  1  state != IDLE
done  output  1  one-cycle pulse at burst completion
mem_en  output  1  to RAM en
mem_rw  output  1  to RAM rw, 1=write
mem_address  output  ADDR_W  to RAM address
mem_in  output  DATA_W  to RAM in
mem_out  input  DATA_W  from RAM out; combinational read of addressed word while mem_en=1, mem_rw=0

Behaviour:
- Reset (async, any state): state IDLE; addr/count/rd_data cleared; rd_valid=0, done=0.
  - cmd_ready forced 0 while reset high.
  - mem_en/mem_rw/mem_address/mem_in = 0.
  - A burst in progress is abandoned; no further mem_en.
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE:
  - cmd_ready=1, busy=0.
  - On cmd handshake: latch cur_addr=cmd_addr, remaining=cmd_len; go WRITE (cmd_rw=1) or READ (cmd_rw=0).
- WRITE:
  - wr_ready=1.
  - Beat cycle (wr_valid=1): mem_en=1, mem_rw=1, mem_address=cur_addr, mem_in=wr_data, all combinational. RAM writes at that clk edge.
  - Per beat: cur_addr+1 mod 64, remaining-1. Beat with remaining==0 -> DONE.
  - wr_valid=0 cycles: mem_en=0, no state change.
- READ:
  - Issue a beat when !rd_valid || rd_ready. Beat drives mem_en=1, mem_rw=0, mem_address=cur_addr.
  - At the edge: rd_data<=mem_out, rd_valid<=1, address/count step.
  - Latency 1 cycle from issue to rd_valid.
  - If rd_valid && !rd_ready: no issue, rd_data held stable (back-pressure).
  - Last issue -> DRAIN.
- DRAIN: no mem access; when rd_valid&rd_ready -> rd_valid<=0, go DONE.
- DONE: done=1 for exactly one cycle, busy=1; next cycle IDLE. A command is accepted no earlier than the cycle after done.
- Wrap-around: address 63 increments to 0. A 64-beat burst touches every word exactly once.
- Outside beat cycles mem_en=0. mem_in and mem_address are 0 when not in a write beat / any beat.
- wr_ready=0 outside WRITE. rd_valid never asserts during a write burst.

Test Plan:
- Reset then IDLE: cmd_ready=1, busy=0, mem_en=0. Asserting reset mid-cycle clears all outputs immediately, without waiting for clk.
- Write burst addr=5 len=3, data A1,A2,A3,A4 with no stalls -> mem_en high 4 cycles at addresses 5..8, mem_rw=1; done pulses once. Read burst addr=5 len=3 with rd_ready=1 -> rd_data A1..A4, each 1 cycle after issue.
- Wrap: write addr=62 len=3 data 1,2,3,4 -> RAM words 62,63,0,1 = 1,2,3,4. Read-back confirms the same values.
- Back-pressure: read len=2 with rd_ready low for 3 cycles after first rd_valid -> rd_data stable, mem_en=0 while stalled, no lost or duplicated words.
- Write stalls: wr_valid toggling 1,0,0,1 on a len=1 write -> exactly 2 mem writes; mem_en=0 on gap cycles.
- Reset mid-write at beat 2 of len=7 -> no mem_en after reset, cmd_ready=1 after release. A new 1-beat read of the start address returns the beat-0 data.
